// File: rtl/tamagotchi_pkg.sv
// Shared encodings for the pet: pet FSM states, level range,
// need-controller states and served-action codes.
package tamagotchi_pkg;

    typedef enum logic [2:0] {
        NEUTRO     = 3'b000,
        FELIZ      = 3'b001,
        TRISTE     = 3'b010,
        HAMBRIENTO = 3'b011,
        ABURRIDO   = 3'b100,
        MUERTO     = 3'b101
    } estado_mascota_t;

    localparam logic [2:0] NIVEL_MIN = 3'd1;
    localparam logic [2:0] NIVEL_MAX = 3'd5;

    typedef enum logic [1:0] {
        LIBRE    = 2'b00,
        OCUPADO  = 2'b01,
        MUERTO_F = 2'b10
    } estado_ctrl_t;

    localparam logic [1:0] ACC_NINGUNA   = 2'b00;
    localparam logic [1:0] ACC_ALIMENTAR = 2'b01;
    localparam logic [1:0] ACC_JUGAR     = 2'b10;

    function automatic logic [2:0] limitar(input logic signed [3:0] v);
        if (v < 4'sd1)
            return NIVEL_MIN;
        if (v > 4'sd5)
            return NIVEL_MAX;
        return v[2:0];
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Two-flop synchronizer followed by a rising-edge detector;
// emits a single-cycle pulse per button press.
module detector_flanco
    import tamagotchi_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic boton,
    output logic pulso
);

    logic s0, s1, prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s0   <= boton;
            s1   <= s0;
            prev <= s1;
        end
    end

    assign pulso = s1 & ~prev;

endmodule

// File: rtl/controlador_niveles.sv
// Hunger/fun level sequencer: prescaled decay timers, feed/play
// arbitration with cooldown, and a freeze once the pet dies.
module controlador_niveles
    import tamagotchi_pkg::*;
#(
    parameter int PRESC             = 50_000_000,
    parameter int PERIODO_HAMBRE    = 10,
    parameter int PERIODO_DIVERSION = 15,
    parameter int COOLDOWN          = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_alimentar,
    input  logic       btn_jugar,
    input  logic [2:0] estado_actual,
    output logic [2:0] nivel_hambre,
    output logic [2:0] nivel_diversion,
    output logic       ocupado,
    output logic [1:0] accion_servida
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int HW = (PERIODO_HAMBRE > 1) ? $clog2(PERIODO_HAMBRE) : 1;
    localparam int DW = (PERIODO_DIVERSION > 1) ? $clog2(PERIODO_DIVERSION) : 1;
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    estado_ctrl_t estado;
    logic [PW-1:0] presc;
    logic [HW-1:0] cnt_h;
    logic [DW-1:0] cnt_d;
    logic [CW-1:0] cnt_cd;
    logic pend_f, pend_j;
    logic req_f, req_j;

    logic tick, wrap_h, wrap_d, cd_fin, muere;
    logic pide_f, pide_j, puede, sirve_f, sirve_j;
    logic signed [3:0] dh, dd, suma_h, suma_d;

    detector_flanco u_det_alimentar (
        .clk   (clk),
        .reset (reset),
        .boton (btn_alimentar),
        .pulso (req_f)
    );

    detector_flanco u_det_jugar (
        .clk   (clk),
        .reset (reset),
        .boton (btn_jugar),
        .pulso (req_j)
    );

    always_comb begin
        tick    = (presc == PW'(PRESC - 1));
        wrap_h  = tick && (cnt_h == HW'(PERIODO_HAMBRE - 1));
        wrap_d  = tick && (cnt_d == DW'(PERIODO_DIVERSION - 1));
        cd_fin  = (cnt_cd == CW'(COOLDOWN - 1));
        muere   = (estado_actual == MUERTO);
        pide_f  = pend_f | req_f;
        pide_j  = pend_j | req_j;
        // the final cooldown cycle also serves, so back-to-back actions
        // are spaced exactly COOLDOWN cycles apart
        puede   = (estado == LIBRE) || (estado == OCUPADO && cd_fin);
        sirve_f = puede && pide_f;
        sirve_j = puede && !pide_f && pide_j;
        dh = 4'sd0;
        dd = 4'sd0;
        if (wrap_h)  dh = dh + 4'sd1;
        if (sirve_f) dh = dh - 4'sd2;
        if (sirve_j) dh = dh + 4'sd1;
        if (wrap_d)  dd = dd - 4'sd1;
        if (sirve_j) dd = dd + 4'sd1;
        suma_h = $signed({1'b0, nivel_hambre}) + dh;
        suma_d = $signed({1'b0, nivel_diversion}) + dd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado          <= LIBRE;
            presc           <= '0;
            cnt_h           <= '0;
            cnt_d           <= '0;
            cnt_cd          <= '0;
            pend_f          <= 1'b0;
            pend_j          <= 1'b0;
            nivel_hambre    <= 3'd1;
            nivel_diversion <= 3'd3;
            ocupado         <= 1'b0;
            accion_servida  <= ACC_NINGUNA;
        end else if (estado == MUERTO_F) begin
            ocupado        <= 1'b0;
            accion_servida <= ACC_NINGUNA;
            pend_f         <= 1'b0;
            pend_j         <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                cnt_h <= wrap_h ? '0 : cnt_h + 1'b1;
                cnt_d <= wrap_d ? '0 : cnt_d + 1'b1;
            end
            nivel_hambre    <= limitar(suma_h);
            nivel_diversion <= limitar(suma_d);
            pend_f <= pide_f & ~sirve_f;
            pend_j <= pide_j & ~sirve_j;
            unique case (1'b1)
                sirve_f: accion_servida <= ACC_ALIMENTAR;
                sirve_j: accion_servida <= ACC_JUGAR;
                default: accion_servida <= ACC_NINGUNA;
            endcase
            if (muere) begin
                estado  <= MUERTO_F;
                ocupado <= 1'b0;
            end else if (sirve_f || sirve_j) begin
                estado  <= OCUPADO;
                ocupado <= 1'b1;
                cnt_cd  <= '0;
            end else if (estado == OCUPADO) begin
                if (cd_fin) begin
                    estado  <= LIBRE;
                    ocupado <= 1'b0;
                end else begin
                    cnt_cd <= cnt_cd + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/controlador_niveles.md
# controlador_niveles

Sequencer for the pet's need levels: generates `nivel_hambre` and `nivel_diversion` (1..5) that drive the pet state machine. Levels decay on prescaled timers; feed/play buttons raise them. Requests are arbitrated with fixed priority and a cooldown window. Sits between the board buttons and the pet FSM, and takes the FSM's `estado_actual` back to freeze everything once the pet is dead.

## Interface
- `PRESC`, 50_000_000: clk cycles per base tick (1 s at 50 MHz)
- `PERIODO_HAMBRE`, 10: base ticks per hunger increment
- `PERIODO_DIVERSION`, 15: base ticks per diversion decrement
- `COOLDOWN`, 25_000_000: clk cycles the controller stays busy after a served action
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `btn_alimentar`  in  1  feed button, asynchronous, already debounced, active-high
- `btn_jugar`  in  1  play button, asynchronous, already debounced, active-high
- `estado_actual`  in  3  pet FSM state; 3'b101 = MUERTO
- `nivel_hambre`  out  3  hunger 1..5 (5 = starving)
- `nivel_diversion`  out  3  fun 1..5 (5 = max)
- `ocupado`  out  1  high during cooldown
- `accion_servida`  out  2  one-cycle pulse: 2'b01 feed served, 2'b10 play served, else 00

## Operation
- Reset (sampled on `clk` rising edge): `nivel_hambre`=1, `nivel_diversion`=3, `ocupado`=0, `accion_servida`=00, all counters, pending flags and sync flops cleared, FSM in LIBRE.
- Each button goes through a 2-flop synchronizer plus a rising-edge detector. It produces a one-cycle request; a held button produces only one request.
- Prescaler counts 0..PRESC-1 and emits `tick` when it wraps. The hunger counter counts ticks 0..PERIODO_HAMBRE-1; at wrap, hunger is incremented by 1. The diversion counter works the same way with PERIODO_DIVERSION; at wrap, diversion is decremented by 1.
- Controller FSM:
  - LIBRE:
    - Pending feed → serve feed, go to OCUPADO.
    - Otherwise pending play → serve play, go to OCUPADO.
  - OCUPADO: count COOLDOWN cycles, then return to LIBRE.
  - MUERTO_F: entered from either state when `estado_actual`==3'b101. It is absorbing; only `reset` exits.
- Pending flags, one per type: set on request in any state except MUERTO_F; cleared when served. A second request of the same type while pending is merged, not counted.
- Feed served: hunger −2. Play served: diversion +1, hunger +1 (playing costs energy).
- Arithmetic: all deltas for one cycle (timer + action) are summed in a 4-bit signed value, then clamped to [1,5]. Levels never leave 1..5.
  - Example: hunger 1, feed + hunger tick together → 1−2+1=0 → 1.
- Simultaneous feed and play requests in LIBRE: feed served first. Play stays pending and is served on the first LIBRE cycle after the cooldown.
- In MUERTO_F: levels, counters and pending flags are frozen or cleared; buttons are ignored; `ocupado`=0.

## Timing
- Button first sampled high at edge k: request pulse is high between k+1 and k+2. If the FSM is LIBRE, levels and `accion_servida` update at edge k+2.
- `ocupado` rises at the same edge as the served update. It stays high for exactly COOLDOWN cycles, then LIBRE resumes, and a pending action is served on that cycle's edge.
- Timer update: level changes at the edge where the period counter wraps. First hunger increment occurs PRESC·PERIODO_HAMBRE cycles after reset release.
- `estado_actual` becoming MUERTO: freeze takes effect from the next edge. An action served on that same edge is still applied.
- Reset mid-cooldown or mid-count: all state returns to reset values on that edge, with no residual pending requests.

## Structure
- Shared package `tamagotchi_pkg`:
  - pet state encodings (NEUTRO..MUERTO, 3'b000..3'b101)
  - NIVEL_MIN=1, NIVEL_MAX=5
  - controller FSM encoding (LIBRE, OCUPADO, MUERTO_F)
  - `accion_servida` codes
- Sub-module `detector_flanco`: 2-flop sync + rising-edge pulse, instantiated once per button.

## Test plan
Benches use PRESC=4, PERIODO_HAMBRE=3, PERIODO_DIVERSION=5, COOLDOWN=8.
- Reset, no input, 12 cycles → hunger 2 at cycle 12. At cycle 20 diversion is 2. Hunger saturates at 5 and diversion at 1, and both stay there.
- Hunger 4, press feed → at edge k+2 hunger 2, `accion_servida`=01, `ocupado` high for exactly 8 cycles.
- Feed and play pressed in the same cycle at hunger 3, diversion 3:
  - feed served first (hunger 1);
  - play served 8 cycles later (diversion 4, hunger 2, `accion_servida`=10).
- Play pressed 3 times during cooldown at diversion 4 → exactly one play served after cooldown. Diversion 5, then it stays 5 on a later play (clamp).
- Hunger 1, feed coinciding with a hunger tick → hunger stays 1. Hunger 5 with a play → hunger stays 5.
- `estado_actual`=3'b101 → levels frozen through 100 cycles of ticks and button presses. Assert `reset` → hunger 1, diversion 3, `ocupado`=0 on the next edge.
